// File: rtl/noc_input_port_if.sv
// Link bundle for the router input port: the upstream flit/credit link and the
// downstream head-of-buffer view used by route/switch allocation.
interface noc_input_port_if #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 5,
  parameter int DEST_W = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  data_i;
  logic              valid_i;
  logic              inc_credit_o;
  logic [WIDTH-1:0]  data_o;
  logic              flit_valid_o;
  logic              pop_i;
  logic [DEST_W-1:0] dest_o;
  logic              route_req_o;
  logic              pkt_active_o;
  logic [CW-1:0]     count_o;
  logic              overflow_o;
  logic              framing_err_o;

  modport slave (
    input  data_i, valid_i, pop_i,
    output inc_credit_o, data_o, flit_valid_o, dest_o, route_req_o,
           pkt_active_o, count_o, overflow_o, framing_err_o
  );

  modport master (
    output data_i, valid_i, pop_i,
    input  inc_credit_o, data_o, flit_valid_o, dest_o, route_req_o,
           pkt_active_o, count_o, overflow_o, framing_err_o
  );
endinterface

// File: rtl/noc_input_port.sv
// Router input port: credit-flow-controlled flit buffer with show-ahead head,
// one-cycle credit return and packet-framing tracker that locks the destination.
module noc_input_port #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 5,
  parameter int DEST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  noc_input_port_if.slave    link
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              not_empty, full;
  logic              pop_eff, push_ok, drop;
  logic              credit_p1;
  logic              ovf_q, ferr_q;
  logic [WIDTH-1:0]  head;
  logic [1:0]        head_type;
  logic [DEST_W-1:0] head_dest;
  logic [DEST_W-1:0] dest_q, dest_nxt;
  state_t            state, state_nxt;
  logic              ferr_set;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign not_empty = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop_eff   = link.pop_i && not_empty;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push_ok   = link.valid_i && (!full || pop_eff);
  assign drop      = link.valid_i && full && !pop_eff;

  assign head      = mem[rd_ptr];
  assign head_type = head[WIDTH-1 -: 2];
  assign head_dest = head[WIDTH-3 -: DEST_W];

  // Stage p0: buffer storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= link.data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      credit_p1 <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_eff) rd_ptr <= next_ptr(rd_ptr);
      unique case ({push_ok, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      credit_p1 <= pop_eff;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Stage p1: packet framing tracker, evaluated on the flit being popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dest_q <= '0;
      ferr_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      dest_q <= dest_nxt;
      if (ferr_set) ferr_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    dest_nxt  = dest_q;
    ferr_set  = 1'b0;
    if (pop_eff) begin
      unique case (state)
        IDLE: begin
          unique case (head_type)
            T_HEAD: begin
              state_nxt = ACTIVE;
              dest_nxt  = head_dest;
            end
            T_SINGLE: state_nxt = IDLE;
            default:  ferr_set  = 1'b1;
          endcase
        end
        ACTIVE: begin
          unique case (head_type)
            T_BODY: state_nxt = ACTIVE;
            T_TAIL: state_nxt = IDLE;
            T_HEAD: begin
              ferr_set = 1'b1;
              dest_nxt = head_dest;
            end
            default: begin
              ferr_set  = 1'b1;
              state_nxt = IDLE;
            end
          endcase
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign link.data_o        = head;
  assign link.flit_valid_o  = not_empty;
  assign link.route_req_o   = not_empty;
  assign link.count_o       = count;
  assign link.inc_credit_o  = credit_p1;
  assign link.overflow_o    = ovf_q;
  assign link.framing_err_o = ferr_q;
  assign link.pkt_active_o  = (state == ACTIVE);
  // Idle shows the waiting packet's destination so allocation can start early.
  assign link.dest_o        = (state == ACTIVE) ? dest_q :
                              (not_empty ? head_dest : '0);

endmodule

// File: tb/tb_noc_input_port.sv
// Scoreboard bench for noc_input_port: accepted flits are queued on push and
// compared against the head on each effective pop; control outputs follow a small model.
module tb_noc_input_port;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 5;
  localparam int DEST_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_input_port_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEST_W(DEST_W)) link ();

  noc_input_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] sb[$];
  logic        m_active;
  logic [3:0]  m_dest;
  logic        m_ferr, m_ovf, m_credit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input logic [1:0] t, input logic [3:0] d,
                                          input logic [9:0] pl);
    return {t, d, pl};
  endfunction

  task automatic model_reset();
    sb.delete();
    m_active = 1'b0;
    m_dest   = '0;
    m_ferr   = 1'b0;
    m_ovf    = 1'b0;
    m_credit = 1'b0;
  endtask

  function automatic logic [3:0] exp_dest();
    if (m_active) return m_dest;
    if (sb.size() > 0) return sb[0][13:10];
    return 4'h0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".count"},  32'(link.count_o), 32'(sb.size()));
    check({tag, ".valid"},  32'(link.flit_valid_o), 32'(sb.size() > 0));
    check({tag, ".rreq"},   32'(link.route_req_o), 32'(sb.size() > 0));
    check({tag, ".credit"}, 32'(link.inc_credit_o), 32'(m_credit));
    check({tag, ".active"}, 32'(link.pkt_active_o), 32'(m_active));
    check({tag, ".dest"},   32'(link.dest_o), 32'(exp_dest()));
    check({tag, ".ovf"},    32'(link.overflow_o), 32'(m_ovf));
    check({tag, ".ferr"},   32'(link.framing_err_o), 32'(m_ferr));
    if (sb.size() > 0) check({tag, ".head"}, 32'(link.data_o), 32'(sb[0]));
  endtask

  // One clock: apply inputs, advance the model, then sample 1 ns after the edge.
  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                      input logic p);
    logic eff;
    int   sz;
    logic [WIDTH-1:0] f;
    link.valid_i = v;
    link.data_i  = d;
    link.pop_i   = p;
    sz  = sb.size();
    eff = p && (sz > 0);
    if (eff) begin
      f = sb.pop_front();
      check({tag, ".pop_data"}, 32'(link.data_o), 32'(f));
      if (!m_active) begin
        case (f[15:14])
          2'b01: begin m_active = 1'b1; m_dest = f[13:10]; end
          2'b11: ;
          default: m_ferr = 1'b1;
        endcase
      end else begin
        case (f[15:14])
          2'b00: ;
          2'b10: m_active = 1'b0;
          2'b01: begin m_ferr = 1'b1; m_dest = f[13:10]; end
          default: begin m_ferr = 1'b1; m_active = 1'b0; end
        endcase
      end
    end
    if (v) begin
      if (sz < DEPTH || eff) sb.push_back(d);
      else m_ovf = 1'b1;
    end
    m_credit = eff;
    @(posedge clk);
    #1;
    link.valid_i = 1'b0;
    link.pop_i   = 1'b0;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    link.valid_i = 1'b0;
    link.pop_i   = 1'b0;
    link.data_i  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Fill to full, no pops
    for (int i = 0; i < DEPTH; i++)
      step("fill", 1'b1, mk(2'b11, 4'(i + 1), 10'(16 + i)), 1'b0);
    // Push and pop while full, then a dropped push
    step("full_pp", 1'b1, mk(2'b11, 4'h9, 10'h155), 1'b1);
    step("full_ovf", 1'b1, mk(2'b11, 4'hE, 10'h3FF), 1'b0);
    step("idle1", 1'b0, '0, 1'b0);
    // Drain across the pointer wrap
    while (sb.size() > 0) step("drain", 1'b0, '0, 1'b1);
    step("pop_empty", 1'b0, '0, 1'b1);
    step("pp_empty", 1'b1, mk(2'b11, 4'h2, 10'h0AA), 1'b1);
    step("pop_single", 1'b0, '0, 1'b1);

    // HEAD/BODY/TAIL packet, one pop per cycle
    step("h", 1'b1, mk(2'b01, 4'hA, 10'h001), 1'b0);
    step("b", 1'b1, mk(2'b00, 4'h1, 10'h002), 1'b0);
    step("t", 1'b1, mk(2'b10, 4'h2, 10'h003), 1'b0);
    repeat (3) step("pkt_pop", 1'b0, '0, 1'b1);
    step("pkt_done", 1'b0, '0, 1'b0);

    // SINGLE then HEAD
    step("s3", 1'b1, mk(2'b11, 4'h3, 10'h011), 1'b0);
    step("h7", 1'b1, mk(2'b01, 4'h7, 10'h012), 1'b0);
    step("pop_s3", 1'b0, '0, 1'b1);
    step("t7", 1'b1, mk(2'b10, 4'h0, 10'h013), 1'b1);
    step("pop_t7", 1'b0, '0, 1'b1);

    // Framing error: BODY popped in IDLE, then legal traffic
    step("stray_b", 1'b1, mk(2'b00, 4'h5, 10'h020), 1'b0);
    step("pop_b", 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      d = 4'($urandom_range(0, 15));
      step("lg_h", 1'b1, mk(2'b01, d, 10'($urandom)), 1'b0);
      step("lg_t", 1'b1, mk(2'b10, 4'($urandom), 10'($urandom)), 1'b1);
      step("lg_p", 1'b0, '0, 1'b1);
    end
    // Illegal HEAD and SINGLE while ACTIVE
    step("a_h1", 1'b1, mk(2'b01, 4'h4, 10'h030), 1'b0);
    step("a_h2", 1'b1, mk(2'b01, 4'hC, 10'h031), 1'b0);
    step("a_s",  1'b1, mk(2'b11, 4'h6, 10'h032), 1'b1);
    step("a_p",  1'b0, '0, 1'b1);
    step("a_p2", 1'b0, '0, 1'b1);

    // Async reset mid-packet with 2 flits still buffered
    step("r_h", 1'b1, mk(2'b01, 4'hB, 10'h040), 1'b0);
    step("r_b", 1'b1, mk(2'b00, 4'h0, 10'h041), 1'b0);
    step("r_t", 1'b1, mk(2'b10, 4'h0, 10'h042), 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async.count",  32'(link.count_o), 32'd0);
    check("async.active", 32'(link.pkt_active_o), 32'd0);
    check("async.credit", 32'(link.inc_credit_o), 32'd0);
    check("async.valid",  32'(link.flit_valid_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("post_rst");
    step("rst_pop", 1'b0, '0, 1'b1);
    step("rst_pop2", 1'b1, mk(2'b11, 4'h8, 10'h050), 1'b0);
    step("rst_pop3", 1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
